decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Registered decode and issue stage for the vector core, between instruction fetch and the execute/ALU stage. It accepts one instruction per cycle over a valid/ready handshake and holds the decoded fields in an execute register. It resolves branches and jumps from that register and squashes wrong-path fetches for a programmable number of cycles. It stalls issue while a load/store waits for its memory acknowledge. The lane count, field widths and flush depth are all parameters.

## Interface
- WIDTH_INSTR, 32, instruction word width
- WIDTH_VECTOR, 8, lane count; width of we_rf and data_imm (power of 2)
- WA_RF, 8, register address width
- WIDTH_OPCODE, 4, opcode width (at least 4)
- WIDTH_JDATA, 24, jump target width
- WA_MEM_SIGN, 20, memory address width; must satisfy WA_MEM_SIGN <= WIDTH_INSTR-WIDTH_OPCODE-WA_RF
- FLUSH_CYCLES, 2, wrong-path fetches discarded after a taken jump (0 allowed)
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- instr  input  WIDTH_INSTR  fetched instruction
- instr_valid  input  1  instr is present
- instr_ready  output  1  stage accepts instr this cycle
- zero  input  1  ALU zero flag for the instruction in the execute register
- mem_ack  input  1  memory has completed the pending load/store
- ext_flush  input  1  external kill of the execute register and of fetch
- dec_valid  output  1  execute register holds a live instruction
- opcode  output  WIDTH_OPCODE  registered opcode
- addr_rega, addr_regb  output  WA_RF each  registered register addresses
- mem_addr  output  WA_MEM_SIGN  registered memory address
- jdata  output  WIDTH_JDATA  registered jump target
- data_imm  output  WIDTH_VECTOR  registered immediate
- we_rf  output  WIDTH_VECTOR  per-lane register write enable
- mem_we, mem_alu, mem_req  output  1 each  store, load-to-ALU, memory request
- jump  output  1  branch/jump taken this cycle; target is jdata

## Operation
- Field slicing:
  - opcode = top WIDTH_OPCODE bits.
  - addr_rega, then addr_regb, are the next WA_RF bits each.
  - mem_addr = low WA_MEM_SIGN bits below addr_rega.
  - jdata = low WIDTH_JDATA bits.
  - data_imm = low WIDTH_VECTOR bits.
- Opcodes:
  - FILL = 0110: we_rf all ones.
  - BRZ = 1001: jump if zero.
  - JMP = 1010: unconditional jump.
  - ST = 1011: mem_we.
  - LD = 1100: mem_alu.
  - NOP = 1101.
  - BRZ, JMP and NOP drive we_rf = 0. Every other opcode drives we_rf = data_imm.
- Qualification: we_rf, mem_we, mem_alu, mem_req and jump are all forced to 0 when dec_valid = 0.
- Accept condition: accept = instr_valid & instr_ready & ~jump & ~ext_flush & (state == RUN).
  - On accept, the execute register loads the decoded instr and dec_valid becomes 1.
  - Otherwise dec_valid becomes 0 (bubble), except during a memory stall, when the register holds.
- Memory stall:
  - mem_req = dec_valid & (ST or LD).
  - stall = mem_req & ~mem_ack.
  - instr_ready = ~stall.
  - In the ack cycle the next instruction may be accepted.
- Jump:
  - jump = dec_valid & (JMP, or BRZ & zero).
  - The instr offered in the jump cycle is discarded.
  - The execute register becomes a bubble.
  - The state goes to FLUSH with the counter set to FLUSH_CYCLES. If FLUSH_CYCLES = 0, the state stays in RUN.
- FSM states are RUN and FLUSH.
  - In FLUSH, instr_ready = 1 and every valid instr is discarded.
  - The counter decrements once per discarded valid instr.
  - When the counter reaches 0, the state returns to RUN.
- ext_flush has the highest priority: it clears dec_valid, aborts any pending memory request, and enters FLUSH exactly as a jump does.

## Timing
- Latency: an instruction accepted at edge k appears on the registered outputs after edge k. jump and mem_req are combinational from that register.
- Reset values:
  - Registered fields: dec_valid, opcode, addr_rega, addr_regb, mem_addr, jdata, data_imm = 0.
  - FSM: state = RUN, flush counter = 0.
  - Outputs while in reset: we_rf, mem_we, mem_alu, mem_req and jump = 0; instr_ready = 1.
- A reset asserted mid-stall or mid-flush takes effect immediately. The pending memory request is dropped; mem_ack arriving after reset is ignored.
- The flush counter is $clog2(FLUSH_CYCLES+1) bits wide and never underflows.
- Back-to-back jumps cannot occur, because the instruction after a jump is always a bubble.
- A jump that arrives while in FLUSH (only possible via ext_flush) reloads the counter.

## Structure
- Package decode_pkg:
  - opcode localparams OP_FILL, OP_BRZ, OP_JMP, OP_ST, OP_LD, OP_NOP;
  - enum state_t {RUN, FLUSH};
  - packed struct dec_fields_t, parameterised through the module's widths.
- One sub-module, instr_field_decode: purely combinational slicing plus the we_rf/mem_we/mem_alu rules, instantiated ahead of the execute register.

## Test plan
- Straight-line issue: FILL, then an ALU op with data_imm = 8'h0F, then NOP, all with instr_valid = 1.
  - dec_valid is 1 on three consecutive cycles.
  - we_rf = 8'hFF, then 8'h0F, then 8'h00.
- JMP with jdata = 24'h000123 and FLUSH_CYCLES = 2:
  - jump = 1 for one cycle with jdata = 24'h000123.
  - The next 3 valid instrs (the one offered in the jump cycle plus 2 flush-cycle fetches) are discarded.
  - The 4th is issued.
- BRZ with zero = 0, then BRZ with zero = 1:
  - The first produces no jump and the following instr issues normally.
  - The second produces jump and a flush.
- ST with mem_ack delayed 3 cycles:
  - mem_req = 1 and mem_we = 1 for 4 cycles.
  - instr_ready = 0 for 3 cycles.
  - Outputs are held; the next instr is accepted in the ack cycle.
- ext_flush during a LD stall, then rst_n pulsed low during FLUSH:
  - mem_req drops on the next cycle.
  - Reset forces all outputs to their reset values, state RUN and instr_ready = 1.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode encodings, issue FSM states and the default-width decoded-field
// record for the decode/issue stage.
package decode_pkg;

    localparam logic [3:0] OP_FILL = 4'b0110;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1100;
    localparam logic [3:0] OP_NOP  = 4'b1101;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH_VECTOR = 8;
    localparam int unsigned DEF_WA_RF        = 8;
    localparam int unsigned DEF_WIDTH_OPCODE = 4;
    localparam int unsigned DEF_WIDTH_JDATA  = 24;
    localparam int unsigned DEF_WA_MEM_SIGN  = 20;

    // Default-width view; modules build the same layout from their own parameters.
    typedef struct packed {
        logic [DEF_WIDTH_OPCODE-1:0] opcode;
        logic [DEF_WA_RF-1:0]        addr_rega;
        logic [DEF_WA_RF-1:0]        addr_regb;
        logic [DEF_WA_MEM_SIGN-1:0]  mem_addr;
        logic [DEF_WIDTH_JDATA-1:0]  jdata;
        logic [DEF_WIDTH_VECTOR-1:0] data_imm;
        logic [DEF_WIDTH_VECTOR-1:0] we_rf;
        logic                        mem_we;
        logic                        mem_alu;
    } dec_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational instruction slicing plus the per-opcode write-enable and
// memory-direction rules, evaluated ahead of the execute register.
module instr_field_decode
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH_INSTR  = 32,
    parameter int unsigned WIDTH_VECTOR = 8,
    parameter int unsigned WA_RF        = 8,
    parameter int unsigned WIDTH_OPCODE = 4,
    parameter int unsigned WIDTH_JDATA  = 24,
    parameter int unsigned WA_MEM_SIGN  = 20
) (
    input  logic [WIDTH_INSTR-1:0]  instr,
    output logic [WIDTH_OPCODE-1:0] opcode,
    output logic [WA_RF-1:0]        addr_rega,
    output logic [WA_RF-1:0]        addr_regb,
    output logic [WA_MEM_SIGN-1:0]  mem_addr,
    output logic [WIDTH_JDATA-1:0]  jdata,
    output logic [WIDTH_VECTOR-1:0] data_imm,
    output logic [WIDTH_VECTOR-1:0] we_rf,
    output logic                    mem_we,
    output logic                    mem_alu
);

    localparam logic [WIDTH_OPCODE-1:0] C_FILL = WIDTH_OPCODE'(OP_FILL);
    localparam logic [WIDTH_OPCODE-1:0] C_BRZ  = WIDTH_OPCODE'(OP_BRZ);
    localparam logic [WIDTH_OPCODE-1:0] C_JMP  = WIDTH_OPCODE'(OP_JMP);
    localparam logic [WIDTH_OPCODE-1:0] C_ST   = WIDTH_OPCODE'(OP_ST);
    localparam logic [WIDTH_OPCODE-1:0] C_LD   = WIDTH_OPCODE'(OP_LD);
    localparam logic [WIDTH_OPCODE-1:0] C_NOP  = WIDTH_OPCODE'(OP_NOP);

    assign opcode    = instr[WIDTH_INSTR-1 -: WIDTH_OPCODE];
    assign addr_rega = instr[WIDTH_INSTR-WIDTH_OPCODE-1 -: WA_RF];
    assign addr_regb = instr[WIDTH_INSTR-WIDTH_OPCODE-WA_RF-1 -: WA_RF];
    assign mem_addr  = instr[WA_MEM_SIGN-1:0];
    assign jdata     = instr[WIDTH_JDATA-1:0];
    assign data_imm  = instr[WIDTH_VECTOR-1:0];

    assign mem_we  = (opcode == C_ST);
    assign mem_alu = (opcode == C_LD);

    always_comb begin
        we_rf = data_imm;
        case (opcode)
            C_FILL:               we_rf = '1;
            C_BRZ, C_JMP, C_NOP:  we_rf = '0;
            default:              we_rf = data_imm;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage: valid/ready intake, execute register, branch
// resolution with wrong-path squash, and load/store acknowledge stall.
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH_INSTR  = 32,
    parameter int unsigned WIDTH_VECTOR = 8,
    parameter int unsigned WA_RF        = 8,
    parameter int unsigned WIDTH_OPCODE = 4,
    parameter int unsigned WIDTH_JDATA  = 24,
    parameter int unsigned WA_MEM_SIGN  = 20,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_INSTR-1:0]  instr,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic                    zero,
    input  logic                    mem_ack,
    input  logic                    ext_flush,
    output logic                    dec_valid,
    output logic [WIDTH_OPCODE-1:0] opcode,
    output logic [WA_RF-1:0]        addr_rega,
    output logic [WA_RF-1:0]        addr_regb,
    output logic [WA_MEM_SIGN-1:0]  mem_addr,
    output logic [WIDTH_JDATA-1:0]  jdata,
    output logic [WIDTH_VECTOR-1:0] data_imm,
    output logic [WIDTH_VECTOR-1:0] we_rf,
    output logic                    mem_we,
    output logic                    mem_alu,
    output logic                    mem_req,
    output logic                    jump
);

    // Counter is kept at least one bit wide so FLUSH_CYCLES = 0 still elaborates.
    localparam int unsigned CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [WIDTH_OPCODE-1:0] C_BRZ = WIDTH_OPCODE'(OP_BRZ);
    localparam logic [WIDTH_OPCODE-1:0] C_JMP = WIDTH_OPCODE'(OP_JMP);

    typedef struct packed {
        logic [WIDTH_OPCODE-1:0] opcode;
        logic [WA_RF-1:0]        addr_rega;
        logic [WA_RF-1:0]        addr_regb;
        logic [WA_MEM_SIGN-1:0]  mem_addr;
        logic [WIDTH_JDATA-1:0]  jdata;
        logic [WIDTH_VECTOR-1:0] data_imm;
        logic [WIDTH_VECTOR-1:0] we_rf;
        logic                    mem_we;
        logic                    mem_alu;
    } exec_t;

    exec_t          d_fields;
    exec_t          ex_q;
    logic           valid_q;
    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           stall;
    logic           accept;

    instr_field_decode #(
        .WIDTH_INSTR  (WIDTH_INSTR),
        .WIDTH_VECTOR (WIDTH_VECTOR),
        .WA_RF        (WA_RF),
        .WIDTH_OPCODE (WIDTH_OPCODE),
        .WIDTH_JDATA  (WIDTH_JDATA),
        .WA_MEM_SIGN  (WA_MEM_SIGN)
    ) u_decode (
        .instr     (instr),
        .opcode    (d_fields.opcode),
        .addr_rega (d_fields.addr_rega),
        .addr_regb (d_fields.addr_regb),
        .mem_addr  (d_fields.mem_addr),
        .jdata     (d_fields.jdata),
        .data_imm  (d_fields.data_imm),
        .we_rf     (d_fields.we_rf),
        .mem_we    (d_fields.mem_we),
        .mem_alu   (d_fields.mem_alu)
    );

    assign jump        = valid_q & ((ex_q.opcode == C_JMP) | ((ex_q.opcode == C_BRZ) & zero));
    assign mem_req     = valid_q & (ex_q.mem_we | ex_q.mem_alu);
    assign stall       = mem_req & ~mem_ack;
    assign instr_ready = ~stall;
    assign accept      = instr_valid & instr_ready & ~jump & ~ext_flush & (state_q == RUN);

    assign dec_valid = valid_q;
    assign opcode    = ex_q.opcode;
    assign addr_rega = ex_q.addr_rega;
    assign addr_regb = ex_q.addr_regb;
    assign mem_addr  = ex_q.mem_addr;
    assign jdata     = ex_q.jdata;
    assign data_imm  = ex_q.data_imm;
    assign we_rf     = valid_q ? ex_q.we_rf : '0;
    assign mem_we    = valid_q & ex_q.mem_we;
    assign mem_alu   = valid_q & ex_q.mem_alu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else if (ext_flush || jump) begin
            valid_q <= 1'b0;
            cnt_q   <= CW'(FLUSH_CYCLES);
            state_q <= (FLUSH_CYCLES > 0) ? FLUSH : RUN;
        end else begin
            if (accept) begin
                ex_q    <= d_fields;
                valid_q <= 1'b1;
            end else if (!stall) begin
                valid_q <= 1'b0;
            end
            // Each wrong-path fetch consumes one squash slot.
            if (state_q == FLUSH && instr_valid) begin
                if (cnt_q <= CW'(1)) begin
                    cnt_q   <= '0;
                    state_q <= RUN;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: a transaction-level model predicts
// issued instructions, handshake and branch outputs for directed and random traffic.
module tb_decode_issue_stage;

    localparam int unsigned FC = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zero;
    logic        mem_ack;
    logic        ext_flush;
    logic        dec_valid;
    logic [3:0]  opcode;
    logic [7:0]  addr_rega;
    logic [7:0]  addr_regb;
    logic [19:0] mem_addr;
    logic [23:0] jdata;
    logic [7:0]  data_imm;
    logic [7:0]  we_rf;
    logic        mem_we;
    logic        mem_alu;
    logic        mem_req;
    logic        jump;

    decode_issue_stage #(
        .WIDTH_INSTR  (32),
        .WIDTH_VECTOR (8),
        .WA_RF        (8),
        .WIDTH_OPCODE (4),
        .WIDTH_JDATA  (24),
        .WA_MEM_SIGN  (20),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .zero        (zero),
        .mem_ack     (mem_ack),
        .ext_flush   (ext_flush),
        .dec_valid   (dec_valid),
        .opcode      (opcode),
        .addr_rega   (addr_rega),
        .addr_regb   (addr_regb),
        .mem_addr    (mem_addr),
        .jdata       (jdata),
        .data_imm    (data_imm),
        .we_rf       (we_rf),
        .mem_we      (mem_we),
        .mem_alu     (mem_alu),
        .mem_req     (mem_req),
        .jump        (jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [19:0] ma;
        logic [23:0] jd;
        logic [7:0]  imm;
        logic [7:0]  we;
        logic        mwe;
        logic        malu;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_extra  = 0;

    // Model: contents of the execute register and remaining squash slots.
    bit   m_valid   = 1'b0;
    exp_t m_cur     = '0;
    int   m_discard = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t predict(input logic [31:0] w);
        exp_t e;
        e.op   = w[31:28];
        e.ra   = w[27:20];
        e.rb   = w[19:12];
        e.ma   = w[19:0];
        e.jd   = w[23:0];
        e.imm  = w[7:0];
        e.mwe  = (e.op == 4'b1011);
        e.malu = (e.op == 4'b1100);
        if (e.op == 4'b0110)
            e.we = 8'hFF;
        else if (e.op == 4'b1001 || e.op == 4'b1010 || e.op == 4'b1101)
            e.we = 8'h00;
        else
            e.we = e.imm;
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [7:0] ra, input logic [19:0] lo);
        return {op, ra, lo};
    endfunction

    // One clock of stimulus: drive on the falling edge, check combinational
    // outputs against the model, then advance the model past the next rising edge.
    task automatic cycle(input logic v, input logic [31:0] w, input logic z,
                         input logic ack, input logic fl);
        bit exp_j, exp_req, exp_stall;
        @(negedge clk);
        instr_valid = v;
        instr       = w;
        zero        = z;
        mem_ack     = ack;
        ext_flush   = fl;
        #1;
        exp_j     = m_valid && (m_cur.op == 4'b1010 || (m_cur.op == 4'b1001 && z));
        exp_req   = m_valid && (m_cur.op == 4'b1011 || m_cur.op == 4'b1100);
        exp_stall = exp_req && !ack;
        check("jump", jump, exp_j);
        check("mem_req", mem_req, exp_req);
        check("instr_ready", instr_ready, !exp_stall);
        if (exp_j) check("jdata", jdata, m_cur.jd);
        if (fl || exp_j) begin
            m_valid   = 1'b0;
            m_discard = FC;
        end else if (exp_stall) begin
            m_valid = m_valid;
        end else if (m_discard > 0) begin
            if (v) m_discard--;
            m_valid = 1'b0;
        end else if (v) begin
            m_valid = 1'b1;
            m_cur   = predict(w);
        end else begin
            m_valid = 1'b0;
        end
        if (m_valid) sb_q.push_back(m_cur);
    endtask

    task automatic check_reset_outputs();
        check("rst_dec_valid", dec_valid, 1'b0);
        check("rst_fields", {opcode, addr_rega, addr_regb, mem_addr, jdata, data_imm}, '0);
        check("rst_ctrl", {we_rf, mem_we, mem_alu, mem_req, jump}, '0);
        check("rst_instr_ready", instr_ready, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        ext_flush   = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_reset_outputs();
        check("sb_empty_before_reset", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        m_valid   = 1'b0;
        m_discard = 0;
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    // Monitor: every live execute-register cycle must match the next prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (dec_valid) begin
                if (sb_q.size() == 0) begin
                    n_extra++;
                end else begin
                    e = sb_q.pop_front();
                    check("issue", {opcode, addr_rega, addr_regb, mem_addr, jdata,
                                    data_imm, we_rf, mem_we, mem_alu}, e);
                end
            end else begin
                check("bubble_quiet", {we_rf, mem_we, mem_alu, mem_req, jump}, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [3:0] ops [7];

    initial begin
        logic [3:0] op;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        zero        = 1'b0;
        mem_ack     = 1'b0;
        ext_flush   = 1'b0;
        ops = '{4'b0110, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0000};
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Straight-line issue: FILL, ALU op with imm 0x0F, NOP.
        cycle(1, mk(4'b0110, 8'h11, 20'h22233), 0, 0, 0);
        cycle(1, mk(4'b0001, 8'h12, 20'h3450F), 0, 0, 0);
        cycle(1, mk(4'b1101, 8'h13, 20'h00077), 0, 0, 0);
        cycle(0, '0, 0, 0, 0);

        // JMP to 0x000123, three wrong-path fetches squashed, fourth issued.
        cycle(1, mk(4'b1010, 8'h00, 20'h00123), 0, 0, 0);
        cycle(1, mk(4'b0010, 8'h01, 20'h00001), 0, 0, 0);
        cycle(1, mk(4'b0010, 8'h02, 20'h00002), 0, 0, 0);
        cycle(1, mk(4'b0010, 8'h03, 20'h00003), 0, 0, 0);
        cycle(1, mk(4'b0011, 8'h04, 20'h000A5), 0, 0, 0);
        cycle(0, '0, 0, 0, 0);

        // BRZ not taken, then BRZ taken.
        cycle(1, mk(4'b1001, 8'h05, 20'h00400), 0, 0, 0);
        cycle(1, mk(4'b0110, 8'h06, 20'h00006), 0, 0, 0);
        cycle(1, mk(4'b1001, 8'h07, 20'h00500), 0, 0, 0);
        cycle(1, mk(4'b0100, 8'h08, 20'h00008), 1, 0, 0);
        cycle(1, mk(4'b0100, 8'h09, 20'h00009), 0, 0, 0);
        cycle(1, mk(4'b0100, 8'h0A, 20'h0000A), 0, 0, 0);
        cycle(1, mk(4'b0100, 8'h0B, 20'h0003C), 0, 0, 0);

        // ST with acknowledge three cycles late; next instr taken in the ack cycle.
        cycle(1, mk(4'b1011, 8'h0C, 20'hABCDE), 0, 0, 0);
        cycle(1, mk(4'b0101, 8'h0D, 20'h000F0), 0, 0, 0);
        cycle(1, mk(4'b0101, 8'h0D, 20'h000F0), 0, 0, 0);
        cycle(1, mk(4'b0101, 8'h0D, 20'h000F0), 0, 0, 0);
        cycle(1, mk(4'b0101, 8'h0D, 20'h000F0), 0, 1, 0);
        cycle(0, '0, 0, 0, 0);

        // ext_flush during an LD stall, then reset in the middle of the flush.
        cycle(1, mk(4'b1100, 8'h0E, 20'h12345), 0, 0, 0);
        cycle(1, mk(4'b0111, 8'h0F, 20'h00011), 0, 0, 0);
        cycle(1, mk(4'b0111, 8'h0F, 20'h00011), 0, 0, 1);
        cycle(0, '0, 0, 1, 0);
        cycle(1, mk(4'b0111, 8'h10, 20'h00012), 0, 0, 0);
        pulse_reset();
        cycle(1, mk(4'b0110, 8'h20, 20'h00099), 0, 0, 0);
        cycle(0, '0, 0, 0, 0);

        // Randomised traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 4'b0000) op = 4'($urandom);
            cycle(($urandom_range(0, 9) < 8), {op, 28'($urandom)},
                  1'($urandom), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0));
        end

        for (int unsigned i = 0; i < 6; i++) cycle(0, '0, 0, 1, 0);
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("no_unexpected_issue", n_extra, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
